// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if: fetch/register-file/execute bus of the decode stage
interface id_stage_pipe_if #(
  parameter int XLEN = 32,
  parameter int RF_AW = 5,
  parameter int CNT_W = 16
);
  logic in_valid;
  logic in_ready;
  logic [31:0] instr;
  logic [XLEN-1:0] pc_plus4;
  logic [RF_AW-1:0] rf_raddr0;
  logic [RF_AW-1:0] rf_raddr1;
  logic [XLEN-1:0] rf_rdata0;
  logic [XLEN-1:0] rf_rdata1;
  logic flush;
  logic redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic out_valid;
  logic out_ready;
  logic [3:0] out_alu_func;
  logic [1:0] out_mem_op;
  logic [1:0] out_br;
  logic [XLEN-1:0] out_op1;
  logic [XLEN-1:0] out_op2;
  logic [XLEN-1:0] out_store_data;
  logic [4:0] out_shamt;
  logic [XLEN-1:0] out_br_target;
  logic [RF_AW-1:0] out_rd;
  logic out_we;
  logic out_illegal;
  logic [CNT_W-1:0] bubble_cnt;
  modport master (
    output in_valid, instr, pc_plus4, rf_rdata0, rf_rdata1, flush, out_ready,
    input in_ready, rf_raddr0, rf_raddr1, redirect_valid, redirect_pc, out_valid,
    out_alu_func, out_mem_op, out_br, out_op1, out_op2, out_store_data, out_shamt,
    out_br_target, out_rd, out_we, out_illegal, bubble_cnt
  );
  modport slave (
    input in_valid, instr, pc_plus4, rf_rdata0, rf_rdata1, flush, out_ready,
    output in_ready, rf_raddr0, rf_raddr1, redirect_valid, redirect_pc, out_valid,
    out_alu_func, out_mem_op, out_br, out_op1, out_op2, out_store_data, out_shamt,
    out_br_target, out_rd, out_we, out_illegal, bubble_cnt
  );
endinterface

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: MIPS decode stage with ID/EX register, load-use bubbles and j/jr redirect
module id_stage_pipe #(
  parameter int XLEN = 32,
  parameter int RF_AW = 5,
  parameter int ZEXT_LOGIC_IMM = 1,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  id_stage_pipe_if.slave bus
);
  localparam logic [3:0] ADD = 4'd1, SUB = 4'd2, AND = 4'd3, OR = 4'd4, XOR = 4'd5;
  localparam logic [3:0] NOR = 4'd6, SRA = 4'd7, SLT = 4'd8;
  localparam logic [1:0] LW = 2'd1, SW = 2'd2;
  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] mem;
    logic [1:0] br;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] sd;
    logic [4:0] shamt;
    logic [XLEN-1:0] tgt;
    logic [RF_AW-1:0] rd;
    logic we;
    logic ill;
  } idex_t;
  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd;
  logic [15:0] imm16;
  logic [3:0] alu;
  logic [1:0] mem, br;
  logic imm_b, sra_a, rdst, wr, ill, is_j, is_jr, u_rs, u_rt, zx;
  logic [XLEN-1:0] sext, imm;
  logic [RF_AW-1:0] dst;
  logic hazard, stall, ready;
  idex_t ex_d, ex_q;
  logic valid_q;
  logic [CNT_W-1:0] cnt_q;
  assign op = bus.instr[31:26];
  assign rs = bus.instr[25:21];
  assign rt = bus.instr[20:16];
  assign rd = bus.instr[15:11];
  assign fn = bus.instr[5:0];
  assign imm16 = bus.instr[15:0];
  always_comb begin
    alu = '0;
    mem = '0;
    br = '0;
    imm_b = 1'b0;
    sra_a = 1'b0;
    rdst = 1'b0;
    wr = 1'b0;
    ill = 1'b0;
    is_j = 1'b0;
    is_jr = 1'b0;
    u_rs = 1'b1;
    u_rt = 1'b0;
    zx = 1'b0;
    if (op == 6'h00) begin
      rdst = 1'b1;
      u_rt = 1'b1;
      wr = 1'b1;
      case (fn)
        6'h20: alu = ADD;
        6'h22: alu = SUB;
        6'h24: alu = AND;
        6'h25: alu = OR;
        6'h26: alu = XOR;
        6'h27: alu = NOR;
        6'h03: begin alu = SRA; sra_a = 1'b1; u_rs = 1'b0; end
        6'h08: begin is_jr = 1'b1; wr = 1'b0; u_rt = 1'b0; end
        default: begin ill = 1'b1; wr = 1'b0; u_rs = 1'b0; u_rt = 1'b0; end
      endcase
    end else begin
      case (op)
        6'h08: begin alu = ADD; imm_b = 1'b1; wr = 1'b1; end
        6'h0a: begin alu = SLT; imm_b = 1'b1; wr = 1'b1; end
        6'h0c: begin alu = AND; imm_b = 1'b1; wr = 1'b1; zx = 1'(ZEXT_LOGIC_IMM); end
        6'h0d: begin alu = OR; imm_b = 1'b1; wr = 1'b1; zx = 1'(ZEXT_LOGIC_IMM); end
        6'h0e: begin alu = XOR; imm_b = 1'b1; wr = 1'b1; zx = 1'(ZEXT_LOGIC_IMM); end
        6'h02: begin is_j = 1'b1; u_rs = 1'b0; end
        6'h04: begin alu = SUB; br = 2'd1; u_rt = 1'b1; end
        6'h05: begin alu = SUB; br = 2'd2; u_rt = 1'b1; end
        6'h07: begin alu = SUB; br = 2'd3; end
        6'h23: begin alu = ADD; mem = LW; imm_b = 1'b1; wr = 1'b1; end
        6'h2b: begin alu = ADD; mem = SW; imm_b = 1'b1; u_rt = 1'b1; end
        default: begin ill = 1'b1; u_rs = 1'b0; end
      endcase
    end
  end
  assign sext = {{(XLEN-16){imm16[15]}}, imm16};
  assign imm = zx ? XLEN'(imm16) : sext;
  assign dst = rdst ? RF_AW'(rd) : RF_AW'(rt);
  assign ex_d = '{
    alu: alu,
    mem: mem,
    br: br,
    op1: sra_a ? bus.rf_rdata1 : bus.rf_rdata0,
    op2: imm_b ? imm : bus.rf_rdata1,
    sd: bus.rf_rdata1,
    shamt: bus.instr[10:6],
    tgt: bus.pc_plus4 + (sext << 2),
    rd: dst,
    we: wr & (dst != '0),
    ill: ill
  };
  // only a load still in ID/EX can feed a consumer too late for forwarding
  assign hazard = valid_q & (ex_q.mem == LW) & (ex_q.rd != '0) &
                  ((u_rs & (ex_q.rd == RF_AW'(rs))) | (u_rt & (ex_q.rd == RF_AW'(rt))));
  assign stall = hazard & bus.in_valid;
  assign ready = bus.flush | (!stall & (!valid_q | bus.out_ready));
  assign bus.in_ready = ready;
  assign bus.rf_raddr0 = RF_AW'(rs);
  assign bus.rf_raddr1 = RF_AW'(rt);
  assign bus.redirect_valid = bus.in_valid & ready & !bus.flush & (is_j | is_jr);
  assign bus.redirect_pc = is_jr ? bus.rf_rdata0 : {bus.pc_plus4[XLEN-1:28], bus.instr[25:0], 2'b00};
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ex_q <= '0;
      cnt_q <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (stall) begin
      if (bus.out_ready) begin
        valid_q <= 1'b0;
        cnt_q <= (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      end
    end else if (!valid_q | bus.out_ready) begin
      valid_q <= bus.in_valid;
      ex_q <= ex_d;
    end
  end
  assign bus.out_valid = valid_q;
  assign bus.out_alu_func = ex_q.alu;
  assign bus.out_mem_op = ex_q.mem;
  assign bus.out_br = ex_q.br;
  assign bus.out_op1 = ex_q.op1;
  assign bus.out_op2 = ex_q.op2;
  assign bus.out_store_data = ex_q.sd;
  assign bus.out_shamt = ex_q.shamt;
  assign bus.out_br_target = ex_q.tgt;
  assign bus.out_rd = ex_q.rd;
  assign bus.out_we = ex_q.we;
  assign bus.out_illegal = ex_q.ill;
  assign bus.bubble_cnt = cnt_q;
endmodule
